// File: rtl/param_stack.sv
// param_stack : LIFO stack of DEPTH entries, WIDTH bits each, with a combinational
// top-of-stack view and a peek port that reads any entry below the top.
//
// Optional feature: define PARAM_STACK_ERR_EN to add sticky overflow and underflow
// flags. Without it both flags are tied to 0, err_clr is ignored and no error
// registers exist.
//
// Operation priority each cycle: flush > push&pop (replace top) > push > pop > idle.
// A push and a pop on an empty stack act as a plain push.
// Status outputs depend only on the registered occupancy count.

module param_stack #(
   parameter int WIDTH     = 19,
   parameter int DEPTH     = 16,
   parameter int AFULL_LVL = DEPTH - 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           push_data,
   input  logic [$clog2(DEPTH)-1:0]   rd_idx,
   output logic [WIDTH-1:0]           top_data,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       rd_valid,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       stack_empty,
   output logic                       stack_full,
   output logic                       almost_full,
   input  logic                       err_clr,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int AW = $clog2(DEPTH);

   // Occupancy constants held in count's width so the comparisons need no casts.
   localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   AFULL_CNT = (AW+1)'(AFULL_LVL);
   localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
   localparam logic [AW-1:0] IDX_ONE   = AW'(1);

   // Storage, bottom entry at index 0; entry i holds live data while i < count.
   logic [WIDTH-1:0] mem [DEPTH];

   // Decoded operations for this cycle, after priority resolution.
   logic            is_empty;
   logic            is_full;
   logic            replace_op;
   logic            push_op;
   logic            pop_op;
   logic            push_ok;
   logic            pop_ok;
   logic            wr_en;
   logic            ovf_evt;
   logic            unf_evt;
   logic [AW-1:0]   top_idx;
   logic [AW-1:0]   peek_idx;
   logic [AW-1:0]   wr_addr;

   assign is_empty = (count == '0);
   assign is_full  = (count == DEPTH_CNT);

   // The lower AW bits of count address the next free slot; when the stack is full
   // they wrap to 0, so subtracting one still lands on the top entry (DEPTH-1).
   assign top_idx  = count[AW-1:0] - IDX_ONE;
   assign peek_idx = count[AW-1:0] - IDX_ONE - rd_idx;

   // Resolve flush / replace / push / pop priority into one-hot style enables.
   always_comb begin
      replace_op = 1'b0;
      push_op    = 1'b0;
      pop_op     = 1'b0;
      if (!flush) begin
         if (push && pop && !is_empty) begin
            replace_op = 1'b1;
         end else if (push) begin
            push_op = 1'b1;
         end else if (pop) begin
            pop_op = 1'b1;
         end
      end
   end

   assign push_ok = push_op && !is_full;
   assign pop_ok  = pop_op && !is_empty;
   assign ovf_evt = push_op && is_full;
   assign unf_evt = pop_op && is_empty;

   // A replace writes over the current top; a plain push writes the next free slot.
   assign wr_en   = push_ok || replace_op;
   assign wr_addr = replace_op ? top_idx : count[AW-1:0];

   // Array write port; reset clears every entry so stale data never reappears.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         mem[wr_addr] <= push_data;
      end
   end

   // Occupancy counter; flush only rewinds the count and leaves the array alone.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (flush) begin
         count <= '0;
      end else if (push_ok) begin
         count <= count + CNT_ONE;
      end else if (pop_ok) begin
         count <= count - CNT_ONE;
      end
   end

   // Read side: top view and peek view, both forced to zero when nothing is there.
   always_comb begin
      top_data = '0;
      rd_data  = '0;
      rd_valid = ({1'b0, rd_idx} < count);
      if (!is_empty) begin
         top_data = mem[top_idx];
      end
      if (rd_valid) begin
         rd_data = mem[peek_idx];
      end
   end

   assign stack_empty = is_empty;
   assign stack_full  = is_full;
   assign almost_full = (count >= AFULL_CNT);

`ifdef PARAM_STACK_ERR_EN

   logic overflow_q;
   logic underflow_q;

   // Sticky overflow flag; a new event in the same cycle as err_clr keeps it set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow_q <= 1'b0;
      end else if (ovf_evt) begin
         overflow_q <= 1'b1;
      end else if (err_clr) begin
         overflow_q <= 1'b0;
      end
   end

   // Sticky underflow flag with the same set-wins rule against err_clr.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         underflow_q <= 1'b0;
      end else if (unf_evt) begin
         underflow_q <= 1'b1;
      end else if (err_clr) begin
         underflow_q <= 1'b0;
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;

`else

   // Error reporting is compiled out: flags read as 0 and the event terms go nowhere.
   logic unused_err;
   assign unused_err = ^{err_clr, ovf_evt, unf_evt};
   assign overflow   = 1'b0;
   assign underflow  = 1'b0;

`endif

endmodule

// File: tb/tb_param_stack.sv
// tb_param_stack : randomized and directed self-checking bench for param_stack.
// The reference model is a plain queue (bottom at index 0) plus two sticky bits.
// Define PARAM_STACK_ERR_EN for both bench and design to exercise the error flags.

module tb_param_stack;

   localparam int W  = 19;
   localparam int D  = 16;
   localparam int AF = D - 2;
`ifdef PARAM_STACK_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          push = 1'b0;
   logic          pop = 1'b0;
   logic          flush = 1'b0;
   logic          err_clr = 1'b0;
   logic [W-1:0]  push_data = '0;
   logic [3:0]    rd_idx = '0;
   logic [W-1:0]  top_data;
   logic [W-1:0]  rd_data;
   logic          rd_valid;
   logic [4:0]    count;
   logic          stack_empty;
   logic          stack_full;
   logic          almost_full;
   logic          overflow;
   logic          underflow;

   int checks = 0;
   int passes = 0;

   logic [W-1:0] q[$];
   bit           m_ovf = 1'b0;
   bit           m_unf = 1'b0;

   param_stack #(.WIDTH(W), .DEPTH(D), .AFULL_LVL(AF)) dut (
      .clk(clk), .reset(reset), .push(push), .pop(pop), .flush(flush),
      .push_data(push_data), .rd_idx(rd_idx), .top_data(top_data),
      .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
      .stack_empty(stack_empty), .stack_full(stack_full),
      .almost_full(almost_full), .err_clr(err_clr),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   // Reference behaviour of one clock edge, straight from the stack rules.
   function automatic void model_step(input bit p, input bit o, input bit f,
                                      input logic [W-1:0] d, input bit ec);
      bit oe = 1'b0;
      bit ue = 1'b0;
      if (f) q.delete();
      else if (p && o && q.size() > 0) q[q.size()-1] = d;
      else if (p) begin
         if (q.size() < D) q.push_back(d); else oe = 1'b1;
      end else if (o) begin
         if (q.size() > 0) void'(q.pop_back()); else ue = 1'b1;
      end
      if (ERR_EN) begin
         m_ovf = oe ? 1'b1 : (ec ? 1'b0 : m_ovf);
         m_unf = ue ? 1'b1 : (ec ? 1'b0 : m_unf);
      end
   endfunction

   function automatic logic [W-1:0] exp_top();
      return (q.size() == 0) ? '0 : q[q.size()-1];
   endfunction

   function automatic logic [W-1:0] exp_rd(input int i);
      return (i < q.size()) ? q[q.size()-1-i] : '0;
   endfunction

   // Apply one cycle of stimulus, advance the model, then settle away from the edge.
   task automatic applyStimulus(input bit p, input bit o, input bit f,
                                input logic [W-1:0] d, input bit ec);
      push = p; pop = o; flush = f; push_data = d; err_clr = ec;
      @(posedge clk);
      model_step(p, o, f, d, ec);
      #1;
      push = 1'b0; pop = 1'b0; flush = 1'b0; err_clr = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
      #1;
      checks++; if (count !== 5'd0) $display("[TB] FAIL reset_count got %0d exp 0", count); else passes++;
      checks++; if (stack_empty !== 1'b1) $display("[TB] FAIL reset_empty got %b exp 1", stack_empty); else passes++;
      checks++; if (stack_full !== 1'b0 || almost_full !== 1'b0) $display("[TB] FAIL reset_full got %b/%b exp 0/0", stack_full, almost_full); else passes++;
      checks++; if (top_data !== '0 || rd_valid !== 1'b0 || rd_data !== '0) $display("[TB] FAIL reset_read got top=%h v=%b rd=%h exp 0/0/0", top_data, rd_valid, rd_data); else passes++;
      checks++; if (overflow !== 1'b0 || underflow !== 1'b0) $display("[TB] FAIL reset_flags got %b/%b exp 0/0", overflow, underflow); else passes++;
   endtask

   task automatic test_fill();
      for (int v = 1; v <= D; v++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, W'(v), 1'b0);
         checks++; if (count !== 5'(q.size())) $display("[TB] FAIL fill_count got %0d exp %0d", count, q.size()); else passes++;
         checks++; if (almost_full !== (q.size() >= AF)) $display("[TB] FAIL fill_afull at %0d got %b exp %b", v, almost_full, q.size() >= AF); else passes++;
         checks++; if (top_data !== exp_top()) $display("[TB] FAIL fill_top got %h exp %h", top_data, exp_top()); else passes++;
      end
      checks++; if (count !== 5'd16 || stack_full !== 1'b1) $display("[TB] FAIL fill_full got cnt=%0d full=%b exp 16/1", count, stack_full); else passes++;
      checks++; if (top_data !== 19'h00010) $display("[TB] FAIL fill_top_final got %h exp 00010", top_data); else passes++;
      rd_idx = 4'd15; #1;
      checks++; if (rd_valid !== 1'b1 || rd_data !== 19'h00001) $display("[TB] FAIL fill_peek15 got v=%b %h exp 1 00001", rd_valid, rd_data); else passes++;
      rd_idx = 4'd0;
   endtask

   task automatic test_overflow();
      applyStimulus(1'b1, 1'b0, 1'b0, 19'h7FFFF, 1'b0);
      checks++; if (count !== 5'd16 || top_data !== 19'h00010) $display("[TB] FAIL ovf_hold got cnt=%0d top=%h exp 16 00010", count, top_data); else passes++;
      checks++; if (overflow !== m_ovf) $display("[TB] FAIL ovf_flag got %b exp %b", overflow, m_ovf); else passes++;
      applyStimulus(1'b1, 1'b1, 1'b0, 19'h7FFFF, 1'b0);
      checks++; if (count !== 5'd16 || top_data !== 19'h7FFFF) $display("[TB] FAIL ovf_replace got cnt=%0d top=%h exp 16 7ffff", count, top_data); else passes++;
      checks++; if (overflow !== m_ovf) $display("[TB] FAIL ovf_sticky got %b exp %b", overflow, m_ovf); else passes++;
   endtask

   task automatic test_underflow();
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
      checks++; if (overflow !== 1'b0) $display("[TB] FAIL errclr_ovf got %b exp 0", overflow); else passes++;
      for (int k = 0; k < D; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
         checks++; if (count !== 5'(q.size()) || top_data !== exp_top()) $display("[TB] FAIL drain got cnt=%0d top=%h exp %0d %h", count, top_data, q.size(), exp_top()); else passes++;
      end
      applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
      checks++; if (count !== 5'd0 || underflow !== ERR_EN) $display("[TB] FAIL unf_pop got cnt=%0d unf=%b exp 0 %b", count, underflow, ERR_EN); else passes++;
      applyStimulus(1'b1, 1'b1, 1'b0, 19'h12345, 1'b0);
      checks++; if (count !== 5'd1 || top_data !== 19'h12345) $display("[TB] FAIL unf_pushpop got cnt=%0d top=%h exp 1 12345", count, top_data); else passes++;
      checks++; if (underflow !== ERR_EN) $display("[TB] FAIL unf_unchanged got %b exp %b", underflow, ERR_EN); else passes++;
   endtask

   task automatic test_flush();
      for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b0, 1'b0, W'($urandom), 1'b0);
      checks++; if (count !== 5'd5) $display("[TB] FAIL flush_pre got %0d exp 5", count); else passes++;
      applyStimulus(1'b1, 1'b0, 1'b1, 19'h55555, 1'b0);
      checks++; if (count !== 5'd0 || top_data !== '0 || stack_empty !== 1'b1) $display("[TB] FAIL flush_state got cnt=%0d top=%h e=%b exp 0 0 1", count, top_data, stack_empty); else passes++;
      for (int i = 0; i < D; i++) begin
         rd_idx = 4'(i); #1;
         checks++; if (rd_valid !== 1'b0 || rd_data !== '0) $display("[TB] FAIL flush_peek idx %0d got v=%b %h exp 0 0", i, rd_valid, rd_data); else passes++;
      end
      rd_idx = 4'd0;
      applyStimulus(1'b1, 1'b0, 1'b0, 19'h00AAA, 1'b0);
      checks++; if (count !== 5'd1 || top_data !== 19'h00AAA) $display("[TB] FAIL flush_push got cnt=%0d top=%h exp 1 00aaa", count, top_data); else passes++;
   endtask

   task automatic test_async_reset();
      applyStimulus(1'b0, 1'b0, 1'b1, '0, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1);
      checks++; if (underflow !== m_unf || m_unf !== ERR_EN) $display("[TB] FAIL clr_vs_event got %b exp %b", underflow, m_unf); else passes++;
      for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 1'b0, W'(k + 1), 1'b0);
      checks++; if (count !== 5'd3) $display("[TB] FAIL ares_pre got %0d exp 3", count); else passes++;
      push = 1'b1; push_data = 19'h0BEEF;
      @(negedge clk); #2;
      reset = 1'b1;
      q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
      #1;
      checks++; if (count !== 5'd0 || stack_empty !== 1'b1) $display("[TB] FAIL ares_now got cnt=%0d e=%b exp 0 1", count, stack_empty); else passes++;
      checks++; if (overflow !== 1'b0 || underflow !== 1'b0) $display("[TB] FAIL ares_flags got %b/%b exp 0/0", overflow, underflow); else passes++;
      @(posedge clk); #1;
      checks++; if (count !== 5'd0) $display("[TB] FAIL ares_hold got %0d exp 0", count); else passes++;
      @(negedge clk);
      reset = 1'b0; push = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0, 19'h00777, 1'b0);
      checks++; if (count !== 5'd1 || top_data !== 19'h00777) $display("[TB] FAIL ares_first got cnt=%0d top=%h exp 1 00777", count, top_data); else passes++;
   endtask

   task automatic test_random();
      bit p, o, f, ec;
      int bias;
      for (int n = 0; n < 800; n++) begin
         bias = ((n / 100) % 2 == 0) ? 70 : 30;
         p  = ($urandom_range(99) < bias);
         o  = ($urandom_range(99) < (100 - bias));
         f  = ($urandom_range(59) == 0);
         ec = ($urandom_range(9) == 0);
         applyStimulus(p, o, f, W'($urandom), ec);
         rd_idx = 4'($urandom_range(15)); #1;
         checks++; if (count !== 5'(q.size())) $display("[TB] FAIL rnd_count cyc %0d got %0d exp %0d", n, count, q.size()); else passes++;
         checks++; if (top_data !== exp_top()) $display("[TB] FAIL rnd_top cyc %0d got %h exp %h", n, top_data, exp_top()); else passes++;
         checks++; if (rd_valid !== (int'(rd_idx) < q.size()) || rd_data !== exp_rd(int'(rd_idx))) $display("[TB] FAIL rnd_peek cyc %0d idx %0d got v=%b %h exp %h", n, rd_idx, rd_valid, rd_data, exp_rd(int'(rd_idx))); else passes++;
         checks++; if (stack_empty !== (q.size() == 0) || stack_full !== (q.size() == D) || almost_full !== (q.size() >= AF)) $display("[TB] FAIL rnd_status cyc %0d got %b%b%b", n, stack_empty, stack_full, almost_full); else passes++;
         checks++; if (overflow !== m_ovf || underflow !== m_unf) $display("[TB] FAIL rnd_flags cyc %0d got %b/%b exp %b/%b", n, overflow, underflow, m_ovf, m_unf); else passes++;
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_overflow();
      test_underflow();
      test_flush();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/param_stack.md
PARAM_STACK -- requirements
Module: param_stack

Interface
REQ-001 Parameter WIDTH, default 19: data bits per entry, >=1.
REQ-002 Parameter DEPTH, default 16: entries, power of two, >=2; AW = log2(DEPTH).
REQ-003 Parameter AFULL_LVL, default DEPTH-2: almost_full threshold, 1..DEPTH.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-006 push  in  1  request to push push_data this cycle.
REQ-007 pop  in  1  request to discard top entry this cycle.
REQ-008 flush  in  1  synchronous empty-all request.
REQ-009 push_data  in  WIDTH  data pushed.
REQ-010 rd_idx  in  AW  peek depth below top (0 = top).
REQ-011 top_data  out  WIDTH  combinational top entry; 0 when empty.
REQ-012 rd_data  out  WIDTH  combinational entry rd_idx below top; 0 when rd_valid=0.
REQ-013 rd_valid  out  1  rd_idx < count.
REQ-014 count  out  AW+1  registered occupancy, 0..DEPTH.
REQ-015 stack_empty / stack_full / almost_full  out  1 each  count==0 / count==DEPTH / count>=AFULL_LVL.
REQ-016 err_clr  in  1  clears sticky error flags.
REQ-017 overflow / underflow  out  1 each  sticky error flags.

Function
REQ-018 Storage: DEPTH x WIDTH array; all DEPTH entries usable; entry i (0-based from bottom) valid when i < count.
REQ-019 Priority each cycle: flush > push&pop > push > pop > idle.
REQ-020 flush: count <= 0 next edge; array contents untouched; push/pop ignored that cycle; no error raised.
REQ-021 push only, not full: mem[count] <= push_data, count <= count+1; new data visible on top_data the next cycle.
REQ-022 push only, full: no state change; overflow event.
REQ-023 pop only, not empty: count <= count-1; top_data changes next cycle.
REQ-024 pop only, empty: no state change; underflow event.
REQ-025 push and pop, count>=1: replace top, mem[count-1] <= push_data, count unchanged (legal when full).
REQ-026 push and pop, empty: treated as push only; no underflow.
REQ-027 Peek: rd_data = mem[count-1-rd_idx] when rd_valid; pure combinational, zero latency.
REQ-028 All status outputs derive from registered count only; no combinational path from push/pop to status.

Reset
REQ-029 On reset: count=0, all array entries 0, overflow=0, underflow=0; hence stack_empty=1, stack_full=0, almost_full=0, top_data=0, rd_valid=0.
REQ-030 Reset asserted mid-operation overrides any same-cycle push/pop/flush; first operation accepted on the first rising edge after deassertion.

Configuration
REQ-031 Macro PARAM_STACK_ERR_EN defined: overflow/underflow set one cycle after the event (REQ-022/024), hold until err_clr or reset; err_clr same cycle as new event -> flag stays 1 (set wins).
REQ-032 PARAM_STACK_ERR_EN undefined: overflow and underflow tied 0, err_clr ignored, no error registers instantiated; all other behaviour identical.

Verification
REQ-033 Defaults; after reset push 0x00001..0x00010 (16 pushes) -> count=16, stack_full=1, almost_full asserted at count 14, top_data=0x00010; rd_idx=15 -> rd_data=0x00001.
REQ-034 Full stack, push 0x7FFFF alone -> count stays 16, top_data=0x00010, overflow=1 next cycle (ERR_EN); then push+pop 0x7FFFF -> top_data=0x7FFFF, count=16.
REQ-035 Empty stack, pop -> count=0, underflow=1 (ERR_EN), 0 (no ERR_EN); push+pop 0x12345 on empty -> count=1, top_data=0x12345, underflow unchanged.
REQ-036 Count 5, assert flush with push=1 -> count=0, top_data=0, rd_valid=0 for all rd_idx; next push 0x00AAA -> count=1, top_data=0x00AAA.
REQ-037 Count 3, assert reset asynchronously between edges with push=1 -> count=0, flags 0, stack_empty=1 immediately; err_clr and error event same cycle -> flag remains 1.
